fifo_width_upsizer: RTL and testbench

- Downstream consumer of fifo_async.
- Pops narrow DataWidth words from the FIFO read port over valid/ready and packs Ratio consecutive words into one wide output word.
- An input last flag closes a partial word early.
- Double-registered (accumulator + output register), so full throughput is sustained while the sink keeps out_ready_i high.

---
 rtl/fifo_width_upsizer.sv | 118 +++++++++++
 tb/tb_fifo_width_upsizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_width_upsizer.sv
// Packs Ratio narrow beats popped from a FIFO into one wide word.
// in_last_i closes a word early. The accumulator and the output register let a word be handed off while the next one fills.
module fifo_width_upsizer #(
  parameter  int unsigned DataWidth = 4,
  parameter  int unsigned Ratio     = 4,
  localparam int unsigned OutWidth  = DataWidth * Ratio,
  localparam int unsigned CntWidth  = $clog2(Ratio + 1)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OutWidth-1:0] out_data_o,
  output logic [CntWidth-1:0] out_count_o,
  output logic                out_last_o
);

  if (Ratio < 2) begin : g_bad_ratio
    $error("fifo_width_upsizer: Ratio must be >= 2");
  end

  typedef enum logic {FILL, DONE} state_e;

  state_e              state_q, state_d;
  logic [OutWidth-1:0] acc_q, acc_d;
  logic [CntWidth-1:0] idx_q, idx_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic [OutWidth-1:0] out_data_q, out_data_d;
  logic [CntWidth-1:0] out_count_q, out_count_d;
  logic                out_last_q, out_last_d;

  logic xfer;
  logic in_ready;
  logic in_fire;

  always_comb begin
    xfer     = (state_q == DONE) && (!out_valid_q || out_ready_i);
    in_ready = (state_q == FILL) || xfer;
    in_fire  = in_valid_i && in_ready;

    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_count_d = cnt_q;
      out_last_d  = last_q;
      acc_d       = '0;
      idx_d       = '0;
      state_d     = FILL;
    end

    // A beat taken on the transfer edge sees the freshly cleared accumulator.
    if (in_fire) begin
      for (int unsigned k = 0; k < Ratio; k++) begin
        if (CntWidth'(k) == idx_d) begin
          acc_d[k*DataWidth +: DataWidth] = in_data_i;
        end
      end
      if (idx_d == CntWidth'(Ratio - 1) || in_last_i) begin
        state_d = DONE;
        cnt_d   = idx_d + CntWidth'(1);
        last_d  = in_last_i;
      end else begin
        idx_d = idx_d + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= FILL;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_fifo_width_upsizer.sv
// Directed and randomized bench for fifo_width_upsizer.
// A queue-based packing model predicts every emitted word.
module tb_fifo_width_upsizer;
  localparam int unsigned DW = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned OW = DW * R;
  localparam int unsigned CW = $clog2(R + 1);

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [OW-1:0] out_data_o;
  logic [CW-1:0] out_count_o;
  logic          out_last_o;

  fifo_width_upsizer #(.DataWidth(DW), .Ratio(R)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_count_o(out_count_o),
    .out_last_o (out_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    int unsigned   count;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] lanes[$];
  int            checks = 0;
  int            failures = 0;
  int            words_seen = 0;
  bit            hold_v = 1'b0;
  logic [OW-1:0] hold_d;
  logic [CW-1:0] hold_c;
  logic          hold_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs mid-cycle: inspects what the coming rising edge will transfer.
  task automatic monitor();
    word_t w;
    if (!reset_ni) begin
      exp_q.delete();
      lanes.delete();
      hold_v = 1'b0;
      return;
    end
    if (hold_v) begin
      chk("hold_valid", out_valid_o, 1);
      chk("hold_data", out_data_o, hold_d);
      chk("hold_count", out_count_o, hold_c);
      chk("hold_last", out_last_o, hold_l);
    end
    if (out_valid_o) chk("count_nonzero", out_count_o != 0, 1);
    if (out_valid_o && out_ready_i) begin
      chk("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("sb_data", out_data_o, w.data);
        chk("sb_count", out_count_o, w.count);
        chk("sb_last", out_last_o, w.last);
        words_seen++;
      end
    end
    if (in_valid_i && in_ready_o) begin
      lanes.push_back(in_data_i);
      if (lanes.size() == R || in_last_i) begin
        w.data = '0;
        for (int k = 0; k < lanes.size(); k++)
          w.data = w.data | (OW'(lanes[k]) << (k * DW));
        w.count = lanes.size();
        w.last  = in_last_i;
        exp_q.push_back(w);
        lanes.delete();
      end
    end
    hold_v = out_valid_o && !out_ready_i;
    hold_d = out_data_o;
    hold_c = out_count_o;
    hold_l = out_last_o;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    for (int n = 0; n < 50; n++) begin
      if (in_ready_o) begin
        tick();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 0, 1);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  initial begin
    logic [OW-1:0] t4_words [3];
    bit            fire;
    bit            exp_v;
    t4_words[0] = 16'h3210;
    t4_words[1] = 16'h7654;
    t4_words[2] = 16'hBA98;

    repeat (2) tick();
    #2 reset_ni = 1'b1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_count", out_count_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    tick();

    // Full word
    for (int b = 1; b <= 4; b++) send_beat(DW'(b), 1'b0);
    chk("t1_not_yet", out_valid_o, 0);
    tick();
    chk("t1_valid", out_valid_o, 1);
    chk("t1_data", out_data_o, 16'h4321);
    chk("t1_count", out_count_o, 4);
    chk("t1_last", out_last_o, 0);
    tick();
    chk("t1_one_cycle", out_valid_o, 0);

    // Partial words
    send_beat(4'd5, 1'b0);
    send_beat(4'd6, 1'b1);
    tick();
    chk("t2a_valid", out_valid_o, 1);
    chk("t2a_data", out_data_o, 16'h0065);
    chk("t2a_count", out_count_o, 2);
    chk("t2a_last", out_last_o, 1);
    send_beat(4'd9, 1'b1);
    chk("t2b_gap", out_valid_o, 0);
    tick();
    chk("t2b_valid", out_valid_o, 1);
    chk("t2b_data", out_data_o, 16'h0009);
    chk("t2b_count", out_count_o, 1);
    chk("t2b_last", out_last_o, 1);
    tick();

    // Backpressure
    out_ready_i = 1'b0;
    for (int b = 1; b <= 8; b++) send_beat(DW'(b), 1'b0);
    chk("t3_stall_ready", in_ready_o, 0);
    repeat (3) begin
      tick();
      chk("t3_held_valid", out_valid_o, 1);
      chk("t3_held_data", out_data_o, 16'h4321);
      chk("t3_stall_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    tick();
    chk("t3_second_valid", out_valid_o, 1);
    chk("t3_second_data", out_data_o, 16'h8765);
    tick();
    chk("t3_drained", out_valid_o, 0);

    // Throughput
    for (int i = 0; i < 16; i++) begin
      in_valid_i = (i < 12);
      in_data_i  = DW'(i);
      in_last_i  = 1'b0;
      if (i < 12) chk("t4_in_ready", in_ready_o, 1);
      tick();
      exp_v = (i == 4 || i == 8 || i == 12);
      chk("t4_valid", out_valid_o, exp_v);
      if (exp_v) chk("t4_data", out_data_o, t4_words[i/4 - 1]);
    end
    in_valid_i = 1'b0;

    // Reset mid-operation
    out_ready_i = 1'b0;
    for (int b = 1; b <= 6; b++) send_beat(DW'(b), 1'b0);
    tick();
    chk("t5_pre_valid", out_valid_o, 1);
    #3 reset_ni = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid_o, 0);
    chk("t5_rst_data", out_data_o, 0);
    chk("t5_rst_count", out_count_o, 0);
    chk("t5_rst_last", out_last_o, 0);
    tick();
    #2 reset_ni = 1'b1;
    out_ready_i = 1'b1;
    tick();
    chk("t5_in_ready", in_ready_o, 1);
    for (int b = 10; b <= 13; b++) send_beat(DW'(b), 1'b0);
    tick();
    chk("t5_valid", out_valid_o, 1);
    chk("t5_data", out_data_o, 16'hDCBA);
    chk("t5_count", out_count_o, 4);
    chk("t5_last", out_last_o, 0);
    tick();

    // Randomized traffic with random backpressure
    words_seen = 0;
    fire = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid_i || fire) begin
        in_valid_i = ($urandom_range(0, 9) < 7);
        in_data_i  = DW'($urandom);
        in_last_i  = ($urandom_range(0, 5) == 0);
      end
      out_ready_i = ($urandom_range(0, 9) < 6);
      fire = in_valid_i && in_ready_o;
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    send_beat(DW'($urandom), 1'b1);
    repeat (6) tick();
    chk("rand_exp_empty", exp_q.size(), 0);
    chk("rand_lanes_empty", lanes.size(), 0);
    chk("rand_out_idle", out_valid_o, 0);
    chk("rand_words_seen", words_seen > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
